tile_loader: RTL and testbench
==============================

// Module: tile_loader
// PURPOSE
//  Upstream feeder for the fast-convolution engine. Walks an IMG_W x IMG_H input map held in a
//  synchronous-read RAM and builds overlapping 5x5 tiles (stride 3, row-major tile order).
//  Each tile is presented as a param25 vector with a 1-cycle conv_start pulse, and the loader
//  waits for the engine's data_valid before presenting the next tile.
//  The next tile is prefetched into a shadow buffer while the engine computes the current one.
// PARAMETERS
//  IMG_W      14  map width in pixels; (IMG_W-5)%3 must be 0; TILES_X=(IMG_W-2)/3
//  IMG_H      14  map height in pixels; (IMG_H-5)%3 must be 0; TILES_Y=(IMG_H-2)/3
//  AW         16  RAM address width
//  BASE_ADDR   0  RAM address of pixel (0,0)
// PORTS
//  clk         in   1        clock
//  reset       in   1        synchronous, active-high reset
//  run         in   1        start one full-map pass; sampled only when busy=0
//  mem_rd      out  1        RAM read strobe
//  mem_addr    out  AW       RAM read address
//  mem_data    in   NBITS    RAM read data, valid the cycle after mem_rd
//  inputMAP    out  param25  tile to engine; element k = pixel (3*ty+k/5, 3*tx+k%5)
//  conv_start  out  1        1-cycle pulse: inputMAP holds a new tile
//  conv_valid  in   1        engine data_valid: current tile finished
//  tile_x      out  4        column index of the tile on inputMAP
//  tile_y      out  4        row index of the tile on inputMAP
//  busy        out  1        pass in progress
//  done        out  1        1-cycle pulse after the last tile's conv_valid
// BEHAVIOUR
//  Reset: all outputs 0; shadow buffer, counters and flags cleared; fetch FSM -> F_IDLE.
//    Reset mid-pass aborts the pass immediately; no further conv_start is issued.
//  Fetch FSM:
//    F_IDLE: run=1 -> F_READ; busy<=1; tile counters=(0,0); k=0.
//    F_READ: mem_rd=1; mem_addr=BASE_ADDR+(3*ty+k/5)*IMG_W+3*tx+k%5.
//      k runs 0..24, one element per cycle. The read k is delayed 1 cycle and the returned
//      mem_data is written to shadow[k_d]. After k=24 is issued -> F_DRAIN.
//    F_DRAIN: captures element 24; sets full=1 -> F_FULL.
//    F_FULL: mem_rd=0. If outstanding=0 -> transfer.
//  Transfer (one edge):
//    inputMAP<=shadow; tile_x/tile_y<=fetched tile; conv_start<=1 next cycle; outstanding<=1.
//    Then, if this was the last tile -> F_END; otherwise advance tx (wrap to 0 at TILES_X,
//    then ty++) and -> F_READ with k=0.
//  F_END: waits for outstanding=0, then done=1 for 1 cycle, busy<=0 -> F_IDLE.
//  conv_valid clears outstanding. conv_valid while outstanding=0 is ignored.
//  A transfer never occurs in the cycle conv_valid clears outstanding; it occurs the next cycle.
//  inputMAP, tile_x and tile_y change only on a transfer: they stay stable from conv_start
//    until conv_valid.
//  run while busy=1 is ignored.
//  Timing: run sampled in cycle N:
//    mem_rd=1 in cycles N+1..N+25;
//    first conv_start in cycle N+28;
//    fetch of tile 1 starts in cycle N+28.
//  Widths: mem_addr computed at AW bits, no wrap checks. Pixel data passes through unchanged,
//    NBITS from packConv.
// TESTING
//  1) Hold reset 3 cycles -> every output 0, including busy, done and conv_start.
//  2) mem[a]=a, 14x14, engine model replies 9 cycles after start ->
//     tile(0,0) inputMAP[6]=15; tile(1,0) element 0=3; tile(0,1) element 0=42;
//     16 conv_starts; done 1 cycle after the 16th conv_valid.
//  3) run in cycle N -> mem_rd in N+1..N+25, addresses 0..4,14..18,...,56..60;
//     conv_start in N+28 with tile_x=0, tile_y=0.
//  4) Engine stalls 60 cycles before conv_valid ->
//     - inputMAP constant throughout;
//     - exactly 25 reads of tile 1, then mem_rd=0;
//     - second conv_start exactly 2 cycles after conv_valid.
//  5) conv_valid pulsed while idle, and run pulsed mid-pass -> no state change, no extra
//     conv_start, tile order unchanged.
//  6) Reset in cycle N+10 of a pass, then run again -> outputs 0 during reset;
//     new pass re-reads addresses 0..4 and first tile is (0,0).

Source files
------------

// File: rtl/tile_loader.sv
// Tile loader: streams overlapping 5x5 tiles (stride 3) from a synchronous RAM
// to the convolution engine, prefetching the next tile into a shadow buffer.
package packConv;
   localparam int NBITS = 16;
   typedef logic [24:0][NBITS-1:0] param25;
endpackage

module tile_loader
   import packConv::*;
#(
   parameter int          IMG_W     = 14,
   parameter int          IMG_H     = 14,
   parameter int          AW        = 16,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   output logic             mem_rd,
   output logic [AW-1:0]    mem_addr,
   input  logic [NBITS-1:0] mem_data,
   output param25           inputMAP,
   output logic             conv_start,
   input  logic             conv_valid,
   output logic [3:0]       tile_x,
   output logic [3:0]       tile_y,
   output logic             busy,
   output logic             done
);
   localparam int TILES_X = (IMG_W - 2) / 3;
   localparam int TILES_Y = (IMG_H - 2) / 3;

   localparam logic [2:0] F_IDLE  = 3'd0;
   localparam logic [2:0] F_READ  = 3'd1;
   localparam logic [2:0] F_DRAIN = 3'd2;
   localparam logic [2:0] F_FULL  = 3'd3;
   localparam logic [2:0] F_END   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [3:0]    tx_q, tx_d, ty_q, ty_d;
   logic [2:0]    r_q, r_d, c_q, c_d;
   logic [4:0]    kd_q, kd_d;
   logic          rdd_q, rdd_d;
   param25        shadow_q, shadow_d;
   param25        map_q, map_d;
   logic [3:0]    tile_x_q, tile_x_d, tile_y_q, tile_y_d;
   logic          cs_q, cs_d;
   logic          out_q, out_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] row_a, col_a;
   logic          last_tile;

   assign row_a = AW'(32'(ty_q) * 3 + 32'(r_q));
   assign col_a = AW'(32'(tx_q) * 3 + 32'(c_q));
   assign last_tile = (tx_q == 4'(TILES_X - 1)) && (ty_q == 4'(TILES_Y - 1));

   assign mem_rd     = (state_q == F_READ);
   assign mem_addr   = mem_rd ? AW'(BASE_ADDR) + row_a * AW'(IMG_W) + col_a : '0;
   assign inputMAP   = map_q;
   assign conv_start = cs_q;
   assign tile_x     = tile_x_q;
   assign tile_y     = tile_y_q;
   assign busy       = busy_q;
   assign done       = (state_q == F_END) && !out_q;

   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      ty_d     = ty_q;
      r_d      = r_q;
      c_d      = c_q;
      kd_d     = kd_q;
      rdd_d    = 1'b0;
      shadow_d = shadow_q;
      map_d    = map_q;
      tile_x_d = tile_x_q;
      tile_y_d = tile_y_q;
      cs_d     = 1'b0;
      out_d    = out_q;
      busy_d   = busy_q;
      // read data lands one cycle after its strobe
      if (rdd_q) shadow_d[kd_q] = mem_data;
      if (conv_valid) out_d = 1'b0;
      unique case (state_q)
         F_IDLE: begin
            if (run) begin
               state_d = F_READ;
               busy_d  = 1'b1;
               tx_d    = '0;
               ty_d    = '0;
               r_d     = '0;
               c_d     = '0;
            end
         end
         F_READ: begin
            rdd_d = 1'b1;
            kd_d  = 5'(32'(r_q) * 5 + 32'(c_q));
            if (c_q == 3'd4) begin
               c_d = '0;
               if (r_q == 3'd4) state_d = F_DRAIN;
               else r_d = r_q + 3'd1;
            end else begin
               c_d = c_q + 3'd1;
            end
         end
         F_DRAIN: state_d = F_FULL;
         F_FULL: begin
            if (!out_q) begin
               map_d    = shadow_q;
               tile_x_d = tx_q;
               tile_y_d = ty_q;
               cs_d     = 1'b1;
               out_d    = 1'b1;
               if (last_tile) begin
                  state_d = F_END;
               end else begin
                  state_d = F_READ;
                  r_d     = '0;
                  c_d     = '0;
                  if (tx_q == 4'(TILES_X - 1)) begin
                     tx_d = '0;
                     ty_d = ty_q + 4'd1;
                  end else begin
                     tx_d = tx_q + 4'd1;
                  end
               end
            end
         end
         F_END: begin
            if (!out_q) begin
               busy_d  = 1'b0;
               state_d = F_IDLE;
            end
         end
         default: state_d = F_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= F_IDLE;
         tx_q     <= '0;
         ty_q     <= '0;
         r_q      <= '0;
         c_q      <= '0;
         kd_q     <= '0;
         rdd_q    <= 1'b0;
         shadow_q <= '0;
         map_q    <= '0;
         tile_x_q <= '0;
         tile_y_q <= '0;
         cs_q     <= 1'b0;
         out_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         ty_q     <= ty_d;
         r_q      <= r_d;
         c_q      <= c_d;
         kd_q     <= kd_d;
         rdd_q    <= rdd_d;
         shadow_q <= shadow_d;
         map_q    <= map_d;
         tile_x_q <= tile_x_d;
         tile_y_q <= tile_y_d;
         cs_q     <= cs_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
      end
   end
endmodule

// File: tb/tb_tile_loader.sv
// Bench for tile_loader: directed vectors, timing sequences and randomized
// passes compared against a tile-level reference model.
module tb_tile_loader;
   import packConv::*;
   localparam int W = 14, NT = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             run = 1'b0;
   logic             mem_rd;
   logic [15:0]      mem_addr;
   logic [NBITS-1:0] mem_data = '0;
   param25           inputMAP;
   logic             conv_start, conv_valid, busy, done;
   logic [3:0]       tile_x, tile_y;

   tile_loader #(.IMG_W(14), .IMG_H(14), .AW(16), .BASE_ADDR(0)) dut (
      .clk(clk), .reset(reset), .run(run),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .inputMAP(inputMAP), .conv_start(conv_start), .conv_valid(conv_valid),
      .tile_x(tile_x), .tile_y(tile_y), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [NBITS-1:0] mem [256];
   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr[7:0]];

   // engine: replies eng_delay cycles after conv_start
   int   eng_delay = 9;
   bit   eng_rand = 1'b0;
   int   eng_cnt = 0;
   logic eng_cv = 1'b0, man_cv = 1'b0;
   assign conv_valid = eng_cv | man_cv;
   always @(posedge clk) begin
      eng_cv <= 1'b0;
      if (reset) eng_cnt <= 0;
      else if (conv_start)
         eng_cnt <= (eng_rand ? int'($urandom_range(20, 2)) : eng_delay) - 1;
      else if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) eng_cv <= 1'b1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_start, n_cv, n_done, n_rd0, stab_err;
   int         last_cv_cyc, done_cyc, cv0_cyc;
   logic       rd_at_cv0;
   int         start_cyc [NT];
   param25     cap_map [NT];
   logic [3:0] cap_x [NT], cap_y [NT];
   param25     held;
   logic [3:0] hx, hy;
   bit         tb_out;

   always @(negedge clk) begin
      if (conv_start) begin
         if (n_start < NT) begin
            cap_map[n_start]   = inputMAP;
            cap_x[n_start]     = tile_x;
            cap_y[n_start]     = tile_y;
            start_cyc[n_start] = cyc;
         end
         n_start++;
         held = inputMAP; hx = tile_x; hy = tile_y; tb_out = 1'b1;
      end else if (tb_out && (inputMAP !== held || tile_x !== hx || tile_y !== hy))
         stab_err++;
      if (mem_rd && n_start == 1 && n_cv == 0) n_rd0++;
      if (conv_valid && !reset) begin
         if (n_cv == 0) begin cv0_cyc = cyc; rd_at_cv0 = mem_rd; end
         n_cv++;
         last_cv_cyc = cyc;
         tb_out = 1'b0;
      end
      if (done) begin n_done++; done_cyc = cyc; end
   end

   int errors = 0, checks = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_map(input string nm, input param25 got, input param25 exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // reference: element k of tile (tx,ty) is pixel (3ty+k/5, 3tx+k%5)
   function automatic param25 model_tile(input int tx, input int ty);
      param25 m;
      for (int k = 0; k < 25; k++)
         m[k] = mem[(3 * ty + k / 5) * W + 3 * tx + k % 5];
      return m;
   endfunction

   task automatic clear_mon();
      n_start = 0; n_cv = 0; n_done = 0; n_rd0 = 0; stab_err = 0;
      last_cv_cyc = 0; done_cyc = 0; cv0_cyc = 0; rd_at_cv0 = 1'b0;
      tb_out = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int limit);
      int t = 0;
      while (n_done == 0 && t < limit) begin @(negedge clk); t++; end
      chk({nm, "_done_seen"}, 64'(n_done != 0), 1);
   endtask

   task automatic check_idle_zero(input string nm);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_cs"}, conv_start, 0);
      chk({nm, "_rd"}, mem_rd, 0);
      chk({nm, "_addr"}, mem_addr, 0);
      chk({nm, "_tile"}, {tile_y, tile_x}, 0);
      chk_map({nm, "_map"}, inputMAP, '0);
   endtask

   // run in cycle N: reads N+1..N+25, first conv_start N+28
   task automatic first_tile_seq(input string nm);
      int bad_rd = 0, bad_addr = 0, bad_cs = 0;
      run = 1'b1; @(negedge clk); run = 1'b0;
      for (int i = 0; i < 28; i++) begin
         if (i > 0) @(negedge clk);
         if (i < 27 && mem_rd !== ((i < 25) ? 1'b1 : 1'b0)) bad_rd++;
         if (i < 25 && mem_addr !== 16'((i / 5) * W + i % 5)) bad_addr++;
         if (i < 27 && conv_start !== 1'b0) bad_cs++;
      end
      chk({nm, "_rd_window"}, bad_rd, 0);
      chk({nm, "_addr_seq"}, bad_addr, 0);
      chk({nm, "_no_early_start"}, bad_cs, 0);
      chk({nm, "_start_n28"}, conv_start, 1);
      chk({nm, "_first_tile"}, {tile_y, tile_x}, 0);
      chk({nm, "_fetch1_n28"}, mem_rd, 1);
      chk_map({nm, "_first_map"}, inputMAP, model_tile(0, 0));
   endtask

   typedef struct {
      int tx;
      int ty;
      int k;
      int exp;
   } vec_t;
   vec_t tbl [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl = '{'{0, 0, 6, 15}, '{1, 0, 0, 3}, '{0, 1, 0, 42}, '{3, 3, 24, 195},
              '{2, 1, 12, 78}, '{3, 0, 4, 13}, '{0, 3, 20, 182}, '{1, 2, 7, 103}};
      for (int a = 0; a < 256; a++) mem[a] = NBITS'(a);
      clear_mon();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_zero("reset");
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // ramp map, engine replies after 9 cycles
      clear_mon();
      eng_delay = 9;
      first_tile_seq("ramp");
      wait_done("ramp", 1500);
      chk("ramp_starts", n_start, 16);
      chk("ramp_done_after_cv", 64'(done_cyc - last_cv_cyc), 1);
      chk("ramp_done_count", n_done, 1);
      for (int i = 0; i < 8; i++)
         chk($sformatf("vec%0d_t%0d_%0d_k%0d", i, tbl[i].tx, tbl[i].ty, tbl[i].k),
             64'(cap_map[tbl[i].ty * 4 + tbl[i].tx][tbl[i].k]), 64'(tbl[i].exp));
      repeat (2) @(negedge clk);
      chk("ramp_busy_clear", busy, 0);

      // engine stall of 60 cycles
      clear_mon();
      eng_delay = 60;
      run = 1'b1; @(negedge clk); run = 1'b0;
      wait_done("stall", 3000);
      chk("stall_map_stable", stab_err, 0);
      chk("stall_tile1_reads", n_rd0, 25);
      chk("stall_rd_idle_at_cv", rd_at_cv0, 0);
      chk("stall_start2_gap", 64'(start_cyc[1] - cv0_cyc), 2);
      chk("stall_starts", n_start, 16);

      // spurious conv_valid while idle
      repeat (3) @(negedge clk);
      clear_mon();
      man_cv = 1'b1; @(negedge clk); man_cv = 1'b0;
      begin
         int bad = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || conv_start || mem_rd || done) bad++;
         end
         chk("idle_cv_ignored", bad, 0);
      end

      // random map, random engine latency, run pulsed mid-pass
      for (int a = 0; a < 256; a++) mem[a] = NBITS'($urandom);
      clear_mon();
      eng_rand = 1'b1;
      run = 1'b1; @(negedge clk); run = 1'b0;
      repeat (100) @(negedge clk);
      run = 1'b1; @(negedge clk); run = 1'b0;
      repeat (300) @(negedge clk);
      run = 1'b1; @(negedge clk); run = 1'b0;
      wait_done("rand", 2000);
      chk("rand_starts", n_start, 16);
      chk("rand_done_count", n_done, 1);
      chk("rand_map_stable", stab_err, 0);
      for (int n = 0; n < NT; n++) begin
         chk($sformatf("rand_order%0d", n), {cap_y[n], cap_x[n]}, {4'(n / 4), 4'(n % 4)});
         chk_map($sformatf("rand_tile%0d", n), cap_map[n], model_tile(n % 4, n / 4));
      end
      repeat (40) @(negedge clk);
      chk("rand_no_extra_start", n_start, 16);
      chk("rand_idle", busy, 0);

      // reset in cycle N+10 of a pass, then run again
      eng_rand = 1'b0;
      eng_delay = 9;
      clear_mon();
      run = 1'b1; @(negedge clk); run = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_idle_zero("midreset");
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_no_start", n_start, 0);
      chk("abort_idle", busy, 0);
      clear_mon();
      first_tile_seq("rerun");
      wait_done("rerun", 1500);
      chk("rerun_starts", n_start, 16);
      chk_map("rerun_last", cap_map[15], model_tile(3, 3));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
